// File: rtl/audio_sram_arbiter_pkg.sv
// Shared types and constants for the audio SRAM arbiter: priority modes,
// requester ids and the read-return record.
package audio_sram_arbiter_pkg;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_AUDIO = 1;

    typedef enum logic {
        M_CPU = 1'b0,
        M_AUD = 1'b1
    } master_e;

    // One entry of the read-return stage: what was accepted last cycle and for whom.
    typedef struct packed {
        logic    acc;
        logic    rd;
        logic    oob;
        master_e id;
    } ret_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/audio_sram_arbiter_if.sv
// Avalon-MM requester bundle as seen by the audio SRAM arbiter.
interface audio_sram_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              oob;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid, oob
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid, oob
    );
endinterface

// File: rtl/audio_sram_arbiter_grant.sv
// Per-cycle grant for the two SRAM requesters: round-robin, or audio priority
// with a saturating CPU starvation counter that forces a CPU win at the limit.
module audio_sram_grant
    import audio_sram_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_MODE    = PRIO_RR,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       freeze_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);
    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    master_e          last_q, last_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             tie_to_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= M_AUD;
            starve_q <= '0;
        end else begin
            last_q   <= last_d;
            starve_q <= starve_d;
        end
    end

    assign tie_to_cpu = (PRIO_MODE == PRIO_AUDIO) ? (starve_q == CNT_MAX)
                                                  : (last_q == M_AUD);

    always_comb begin
        grant_o  = '0;
        last_d   = last_q;
        starve_d = starve_q;
        // Frozen cycles neither grant nor age the starvation counter.
        if (!freeze_i && !reset) begin
            unique case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = tie_to_cpu ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase

            if (grant_o[0]) begin
                last_d = M_CPU;
            end else if (grant_o[1]) begin
                last_d = M_AUD;
            end

            if (req_i[0] && !grant_o[0]) begin
                starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

endmodule

// File: rtl/audio_sram_arbiter.sv
// Shares the single-port audio SRAM between the Nios data master (m0) and the
// audio streamer (m1): one access per cycle, 1-cycle read return, range guard.
module audio_sram_arbiter
    import audio_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BE_W         = 4,
    parameter int unsigned DEPTH        = 80000,
    parameter int unsigned PRIO_MODE    = PRIO_RR,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    audio_sram_arbiter_if.slave m0,
    audio_sram_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [BE_W-1:0]     ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    logic [1:0] req;
    logic [1:0] grant;
    master_e    sel;
    logic       acc;
    logic       sel_write;
    logic       in_range;
    logic       rdv0, rdv1;
    ret_t       ret_q, ret_d;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    audio_sram_grant #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .freeze_i (freeze),
        .req_i    (req),
        .grant_o  (grant)
    );

    always_comb begin
        acc            = |grant;
        sel            = grant[1] ? M_AUD : M_CPU;
        ram_address    = m0.address;
        ram_byteenable = m0.byteenable;
        ram_writedata  = m0.writedata;
        sel_write      = m0.write;
        if (sel == M_AUD) begin
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
            sel_write      = m1.write;
        end
        in_range       = addr_in_range(32'(ram_address), DEPTH);
        ram_chipselect = acc & in_range;
        ram_write      = ram_chipselect & sel_write;
        ram_clken      = ~freeze;
        m0.waitrequest = req[0] & ~grant[0];
        m1.waitrequest = req[1] & ~grant[1];
        ret_d.acc      = acc;
        ret_d.rd       = acc & ~sel_write;
        ret_d.oob      = acc & ~in_range;
        ret_d.id       = sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= '0;
        end else begin
            ret_q <= ret_d;
        end
    end

    // Return pulses are masked during reset so a read accepted just before it never surfaces.
    always_comb begin
        rdv0             = ~reset & ret_q.rd & (ret_q.id == M_CPU);
        rdv1             = ~reset & ret_q.rd & (ret_q.id == M_AUD);
        m0.readdatavalid = rdv0;
        m1.readdatavalid = rdv1;
        m0.oob           = ~reset & ret_q.acc & ret_q.oob & (ret_q.id == M_CPU);
        m1.oob           = ~reset & ret_q.acc & ret_q.oob & (ret_q.id == M_AUD);
        m0.readdata      = '0;
        m1.readdata      = '0;
        if (rdv0 && !ret_q.oob) begin
            m0.readdata = ram_readdata;
        end
        if (rdv1 && !ret_q.oob) begin
            m1.readdata = ram_readdata;
        end
    end

endmodule

// File: tb/tb_audio_sram_arbiter.sv
// Bench for audio_sram_arbiter: a round-robin instance and an audio-priority
// instance (STARVE_LIMIT=3), each with its own SRAM, checked against a reference model.
module tb_audio_sram_arbiter;

    localparam int unsigned DEPTH = 80000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        frz  [2];
    logic [16:0] addr [2][2];
    logic        rd   [2][2];
    logic        wr   [2][2];
    logic [3:0]  be   [2][2];
    logic [31:0] wd   [2][2];
    logic        wreq [2][2];
    logic        rdv  [2][2];
    logic [31:0] rdat [2][2];
    logic        oob  [2][2];

    logic [16:0] r_addr  [2];
    logic [3:0]  r_be    [2];
    logic        r_cs    [2];
    logic        r_we    [2];
    logic        r_clken [2];
    logic [31:0] r_wd    [2];
    logic [31:0] r_q     [2];
    bit   [31:0] ram     [2][DEPTH];

    audio_sram_arbiter_if #(.ADDR_W(17), .DATA_W(32), .BE_W(4)) bus [4] ();

    for (genvar i = 0; i < 4; i++) begin : g_bus
        assign bus[i].address    = addr[i/2][i%2];
        assign bus[i].read       = rd[i/2][i%2];
        assign bus[i].write      = wr[i/2][i%2];
        assign bus[i].byteenable = be[i/2][i%2];
        assign bus[i].writedata  = wd[i/2][i%2];
        assign wreq[i/2][i%2]    = bus[i].waitrequest;
        assign rdv[i/2][i%2]     = bus[i].readdatavalid;
        assign rdat[i/2][i%2]    = bus[i].readdata;
        assign oob[i/2][i%2]     = bus[i].oob;
    end

    audio_sram_arbiter #(
        .ADDR_W(17), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH), .PRIO_MODE(0), .STARVE_LIMIT(8)
    ) dut_rr (
        .clk(clk), .reset(rst[0]), .freeze(frz[0]), .m0(bus[0]), .m1(bus[1]),
        .ram_address(r_addr[0]), .ram_byteenable(r_be[0]), .ram_chipselect(r_cs[0]),
        .ram_write(r_we[0]), .ram_writedata(r_wd[0]), .ram_clken(r_clken[0]),
        .ram_readdata(r_q[0])
    );

    audio_sram_arbiter #(
        .ADDR_W(17), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH), .PRIO_MODE(1), .STARVE_LIMIT(3)
    ) dut_pr (
        .clk(clk), .reset(rst[1]), .freeze(frz[1]), .m0(bus[2]), .m1(bus[3]),
        .ram_address(r_addr[1]), .ram_byteenable(r_be[1]), .ram_chipselect(r_cs[1]),
        .ram_write(r_we[1]), .ram_writedata(r_wd[1]), .ram_clken(r_clken[1]),
        .ram_readdata(r_q[1])
    );

    // SRAM with registered read address and clock enable.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (r_clken[d]) begin
                if (r_cs[d] && r_we[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_be[d][b]) ram[d][r_addr[d]][8*b +: 8] <= r_wd[d][8*b +: 8];
                    end
                end
                r_q[d] <= (r_addr[d] < DEPTH) ? ram[d][r_addr[d]] : 32'h0;
            end
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          last_g [2];
    int          starve [2];
    bit          exp_rdv [2][2];
    bit          exp_oob [2][2];
    logic [31:0] exp_dat [2][2];
    bit          acc     [2][2];
    logic [31:0] rmem [int unsigned];
    logic        o_wait [2][2];
    logic        o_rdv  [2][2];
    logic        o_oob  [2][2];
    logic [31:0] o_data [2][2];
    logic        o_cs    [2];
    logic        o_clken [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lim(input int d);
        return (d == 0) ? 8 : 3;
    endfunction

    function automatic logic [31:0] ref_rd(input int d, input logic [16:0] a);
        int unsigned key = d * 131072 + a;
        return rmem.exists(key) ? rmem[key] : 32'h0;
    endfunction

    task automatic ref_wr(input int d, input logic [16:0] a, input logic [3:0] lanes, input logic [31:0] v);
        logic [31:0] m = ref_rd(d, a);
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) m[8*b +: 8] = v[8*b +: 8];
        end
        rmem[d * 131072 + a] = m;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model to the next cycle.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int          g;
            bit          rq [2];
            bit          inr;
            bit          gw;
            logic [16:0] ga;
            rq[0] = rd[d][0] | wr[d][0];
            rq[1] = rd[d][1] | wr[d][1];
            g = -1;
            if (!rst[d] && !frz[d]) begin
                if (rq[0] && rq[1]) begin
                    if (d == 0) g = (last_g[d] == 1) ? 0 : 1;
                    else        g = (starve[d] == lim(d)) ? 0 : 1;
                end else if (rq[0]) begin
                    g = 0;
                end else if (rq[1]) begin
                    g = 1;
                end
            end
            ga  = (g >= 0) ? addr[d][g] : 17'h0;
            gw  = (g >= 0) ? wr[d][g] : 1'b0;
            inr = (g >= 0) && (ga < DEPTH);

            for (int k = 0; k < 2; k++) begin
                o_wait[d][k] = wreq[d][k];
                o_rdv[d][k]  = rdv[d][k];
                o_oob[d][k]  = oob[d][k];
                o_data[d][k] = rdat[d][k];
                check($sformatf("d%0d_m%0d_wait", d, k), wreq[d][k], rq[k] && (g != k));
                check($sformatf("d%0d_m%0d_rdv", d, k), rdv[d][k], exp_rdv[d][k] && !rst[d]);
                check($sformatf("d%0d_m%0d_oob", d, k), oob[d][k], exp_oob[d][k] && !rst[d]);
                if (exp_rdv[d][k] && !rst[d])
                    check($sformatf("d%0d_m%0d_data", d, k), rdat[d][k], exp_dat[d][k]);
            end
            o_cs[d]    = r_cs[d];
            o_clken[d] = r_clken[d];
            check($sformatf("d%0d_cs", d), r_cs[d], inr);
            check($sformatf("d%0d_ramwr", d), r_we[d], inr && gw);
            check($sformatf("d%0d_clken", d), r_clken[d], !frz[d]);

            for (int k = 0; k < 2; k++) begin
                exp_rdv[d][k] = 1'b0;
                exp_oob[d][k] = 1'b0;
                exp_dat[d][k] = 32'h0;
                acc[d][k]     = (g == k);
            end
            if (rst[d]) begin
                last_g[d] = 1;
                starve[d] = 0;
            end else begin
                if (g >= 0) begin
                    if (gw) begin
                        if (inr) ref_wr(d, ga, be[d][g], wd[d][g]);
                    end else begin
                        exp_rdv[d][g] = 1'b1;
                        exp_dat[d][g] = inr ? ref_rd(d, ga) : 32'h0;
                    end
                    exp_oob[d][g] = !inr;
                    last_g[d] = g;
                end
                if (!frz[d]) begin
                    if (rq[0] && g != 0) starve[d] = (starve[d] < lim(d)) ? starve[d] + 1 : starve[d];
                    else                 starve[d] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                rd[d][k] = 1'b0;
                wr[d][k] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 2; k++) begin
                    if (acc[d][k]) begin
                        rd[d][k] = 1'b0;
                        wr[d][k] = 1'b0;
                    end
                end
            end
            step();
        end
        idle_all();
        step();
        step();
    endtask

    task automatic new_req(input int d, input int k);
        int r = int'($urandom_range(0, 7));
        rd[d][k] = (r <= 2) || (r == 6);
        wr[d][k] = (r >= 3) && (r <= 6);
        if ($urandom_range(0, 7) == 0) addr[d][k] = 17'(79998 + $urandom_range(0, 3));
        else                           addr[d][k] = 17'($urandom_range(0, 9));
        be[d][k] = 4'($urandom);
        wd[d][k] = $urandom;
    endtask

    initial begin
        int w, got, v0, v1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            frz[d] = 1'b0;
            last_g[d] = 1;
            starve[d] = 0;
            for (int k = 0; k < 2; k++) begin
                addr[d][k] = '0; rd[d][k] = 1'b0; wr[d][k] = 1'b0;
                be[d][k] = '0; wd[d][k] = '0;
                exp_rdv[d][k] = 1'b0; exp_oob[d][k] = 1'b0; exp_dat[d][k] = '0; acc[d][k] = 1'b0;
            end
        end
        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // First tie after reset: CPU wins round-robin, audio wins priority mode.
        for (int d = 0; d < 2; d++) begin
            rd[d][0] = 1'b1; addr[d][0] = 17'd5;
            rd[d][1] = 1'b1; addr[d][1] = 17'd6;
        end
        step();
        check("rr_first_tie_m0", o_wait[0][0], 1'b0);
        check("rr_first_tie_m1", o_wait[0][1], 1'b1);
        check("pr_first_tie_m1", o_wait[1][1], 1'b0);
        drain();

        // Single write then read-back with 1-cycle latency.
        wr[0][0] = 1'b1; addr[0][0] = 17'h00010; be[0][0] = 4'hF; wd[0][0] = 32'h1234_5678;
        step();
        check("wr_accept", o_wait[0][0], 1'b0);
        wr[0][0] = 1'b0; rd[0][0] = 1'b1;
        step();
        check("rd_accept", o_wait[0][0], 1'b0);
        rd[0][0] = 1'b0;
        step();
        check("rd_rdv", o_rdv[0][0], 1'b1);
        check("rd_data", o_data[0][0], 32'h1234_5678);
        step();
        check("rd_rdv_pulse", o_rdv[0][0], 1'b0);

        // Round-robin under continuous contention; last grant was m0, so m1 goes first.
        rd[0][0] = 1'b1; addr[0][0] = 17'h00010;
        rd[0][1] = 1'b1; addr[0][1] = 17'h00003;
        v0 = 0; v1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_alt_m0", o_wait[0][0], (i % 2) == 0);
            check("rr_alt_m1", o_wait[0][1], (i % 2) == 1);
            v0 += int'(o_rdv[0][0]);
            v1 += int'(o_rdv[0][1]);
        end
        idle_all();
        step();
        v0 += int'(o_rdv[0][0]);
        v1 += int'(o_rdv[0][1]);
        check("rr_rdv_count_m0", v0, 4);
        check("rr_rdv_count_m1", v1, 4);
        step();

        // Priority mode: CPU force-granted on its 4th waiting cycle, then audio resumes.
        rd[1][1] = 1'b1; addr[1][1] = 17'd50;
        rd[1][0] = 1'b1; addr[1][0] = 17'd51;
        w = 0; got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            if (o_wait[1][0] == 1'b0) got = 1;
            else                      w++;
        end
        check("starve_got", got, 1);
        check("starve_wait", w, 3);
        rd[1][0] = 1'b0;
        step();
        check("aud_resume", o_wait[1][1], 1'b0);
        rd[1][1] = 1'b0;
        step();
        step();

        // Partial write over all-ones.
        wr[0][0] = 1'b1; addr[0][0] = 17'h00020; be[0][0] = 4'hF; wd[0][0] = 32'hFFFF_FFFF;
        step();
        be[0][0] = 4'b0010; wd[0][0] = 32'hAABB_CCDD;
        step();
        wr[0][0] = 1'b0; rd[0][0] = 1'b1;
        step();
        rd[0][0] = 1'b0;
        step();
        check("partial_rdv", o_rdv[0][0], 1'b1);
        check("partial_data", o_data[0][0], 32'hFFFF_CCFF);

        // Out-of-range write and read at DEPTH.
        wr[0][1] = 1'b1; addr[0][1] = 17'd80000; be[0][1] = 4'hF; wd[0][1] = 32'hDEAD_BEEF;
        step();
        check("oob_wr_accept", o_wait[0][1], 1'b0);
        check("oob_wr_cs", o_cs[0], 1'b0);
        wr[0][1] = 1'b0; rd[0][1] = 1'b1;
        step();
        check("oob_wr_pulse", o_oob[0][1], 1'b1);
        check("oob_rd_cs", o_cs[0], 1'b0);
        rd[0][1] = 1'b0;
        step();
        check("oob_rd_rdv", o_rdv[0][1], 1'b1);
        check("oob_rd_data", o_data[0][1], 32'h0);
        check("oob_rd_pulse", o_oob[0][1], 1'b1);
        step();
        check("oob_pulse_end", o_oob[0][1], 1'b0);

        // Reset right after an accepted read kills its return.
        rd[0][0] = 1'b1; addr[0][0] = 17'h00010;
        step();
        rd[0][0] = 1'b0; rst[0] = 1'b1;
        step();
        check("rst_kill", o_rdv[0][0], 1'b0);
        rst[0] = 1'b0;
        step();
        check("rst_after", o_rdv[0][0], 1'b0);

        // Freeze while a read is in flight: result delivered, no new grant.
        rd[0][0] = 1'b1; addr[0][0] = 17'h00010;
        step();
        rd[0][0] = 1'b0;
        rd[0][1] = 1'b1; addr[0][1] = 17'h00020; frz[0] = 1'b1;
        step();
        check("frz_rdv", o_rdv[0][0], 1'b1);
        check("frz_data", o_data[0][0], 32'h1234_5678);
        check("frz_wait", o_wait[0][1], 1'b1);
        check("frz_clken", o_clken[0], 1'b0);
        frz[0] = 1'b0;
        step();
        check("unfrz_grant", o_wait[0][1], 1'b0);
        rd[0][1] = 1'b0;
        step();
        check("unfrz_rdv", o_rdv[0][1], 1'b1);
        check("unfrz_data", o_data[0][1], 32'hFFFF_CCFF);
        step();

        // Random traffic on both instances; requests held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!(rd[d][k] || wr[d][k]) || acc[d][k]) new_req(d, k);
                end
                frz[d] = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        frz[0] = 1'b0;
        frz[1] = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
